// File: rtl/i2s_frame_src.sv
// I2S frame source: sample-pair FIFO, frame counter / word-select generator and per-frame data registers.
// Build option: define I2S_HOLD_ON_UNDERRUN_EN to repeat the last pair on underrun instead of outputting zeros.
module i2s_frame_src #(
    parameter int SIZE       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SIZE-1:0]               in_left,
    input  logic [SIZE-1:0]               in_right,
    output logic                          ws,
    output logic [SIZE-1:0]               data_left,
    output logic [SIZE-1:0]               data_right,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    localparam int CNT_W = $clog2(2 * SIZE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SIZE);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ws_q, ws_d;
    logic [SIZE-1:0]      data_l_q, data_l_d;
    logic [SIZE-1:0]      data_r_q, data_r_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full_q, full_d;
    logic                 underrun_q, underrun_d;

    logic [2*SIZE-1:0]    mem [FIFO_DEPTH];

    logic load;
    logic empty;
    logic push;
    logic pop;
    logic underrun_evt;

    assign empty        = (level_q == '0);
    assign push         = in_valid && !full_q;
    assign pop          = load && !empty;
    assign underrun_evt = load && empty;

    // Frame sequencing: a frame always runs to cnt = 2*SIZE-1 before en is honoured again.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (en) load = 1'b1;
                    else    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ws_d = (cnt_d >= CNT_HALF);
    end

    always_comb begin
        data_l_d   = data_l_q;
        data_r_d   = data_r_q;
        wr_ptr_d   = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d   = rd_ptr_q + (pop  ? PTR_W'(1) : PTR_W'(0));
        level_d    = level_q;
        underrun_d = underrun_q;

        if (pop) begin
            {data_l_d, data_r_d} = mem[rd_ptr_q];
        end else if (underrun_evt) begin
`ifdef I2S_HOLD_ON_UNDERRUN_EN
            data_l_d = data_l_q;
            data_r_d = data_r_q;
`else
            data_l_d = '0;
            data_r_d = '0;
`endif
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_FULL);

        // A new underrun on the same edge as a clear must remain visible.
        if (underrun_evt)      underrun_d = 1'b1;
        else if (underrun_clr) underrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ws_q       <= 1'b0;
            data_l_q   <= '0;
            data_r_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ws_q       <= ws_d;
            data_l_q   <= data_l_d;
            data_r_q   <= data_r_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {in_left, in_right};
    end

    assign in_ready   = !full_q;
    assign ws         = ws_q;
    assign data_left  = data_l_q;
    assign data_right = data_r_q;
    assign level      = level_q;
    assign underrun   = underrun_q;

endmodule
